// File: rtl/bram_req_client_if.sv
// Request/response stream bundle between core-side logic and bram_req_client.
interface bram_req_client_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WE_WIDTH   = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WE_WIDTH-1:0]   req_we;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_is_write;

  modport master (
    output req_valid, req_addr, req_we, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_is_write
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_is_write
  );
endinterface

// File: rtl/bram_req_client.sv
// Initiator-side BRAM port adapter: credit-limited request issue, read-latency tag pipe, in-order response FIFO.
// Define BRAM_CLIENT_WRITE_ACK_EN to track writes and return one response per write.
module bram_req_client #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CHUNKSIZE  = 8,
  parameter int unsigned WE_WIDTH   = 4,
  parameter int unsigned PIPELINED  = 0,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  bram_req_client_if.slave      bus,
  output logic                  busy,
  output logic                  bram_en,
  output logic [WE_WIDTH-1:0]   bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_di,
  input  logic [DATA_WIDTH-1:0] bram_do
);

  localparam int unsigned LAT   = 1 + PIPELINED;
  localparam int unsigned PTR_W = $clog2(RESP_DEPTH);
  localparam int unsigned PW    = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

  if (CHUNKSIZE * WE_WIDTH != DATA_WIDTH) begin : g_bad_lanes
    $error("bram_req_client: DATA_WIDTH must equal CHUNKSIZE*WE_WIDTH");
  end
  if (RESP_DEPTH < 2 || (1 << PTR_W) != RESP_DEPTH) begin : g_bad_depth
    $error("bram_req_client: RESP_DEPTH must be a power of 2 and >= 2");
  end

  logic                  rdy_r;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      cnt_next;
  logic [LAT-1:0]        pipe_v;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [RESP_DEPTH];
  logic                  ready_c;
  logic                  accept;
  logic                  tracked;
  logic                  inc;
  logic                  push;
  logic                  pop;
  logic                  resp_valid_c;

  // Credit check uses registered state only, so ready never depends on req_valid.
  assign ready_c      = rdy_r && (outstanding < CNT_W'(RESP_DEPTH));
  assign accept       = bus.req_valid && ready_c;
  assign resp_valid_c = (wr_ptr != rd_ptr);
  assign push         = pipe_v[LAT-1];
  assign pop          = resp_valid_c && bus.resp_ready;
  assign inc          = accept && tracked;

`ifdef BRAM_CLIENT_WRITE_ACK_EN
  logic [LAT-1:0]        pipe_w;
  logic [RESP_DEPTH-1:0] mem_w;

  assign tracked           = 1'b1;
  assign bus.resp_is_write = mem_w[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pipe_w <= '0;
    end else begin
      pipe_w <= LAT'({pipe_w, (bus.req_we != '0)});
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_w[wr_ptr[PTR_W-1:0]] <= pipe_w[LAT-1];
    end
  end
`else
  assign tracked           = (bus.req_we == '0);
  assign bus.resp_is_write = 1'b0;
`endif

  assign bus.req_ready  = ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_data  = mem[rd_ptr[PTR_W-1:0]];

  // BRAM port is a straight passthrough; WE is masked when the port is idle.
  assign bram_en   = accept;
  assign bram_we   = accept ? bus.req_we : '0;
  assign bram_addr = bus.req_addr;
  assign bram_di   = bus.req_data;

  always_comb begin
    cnt_next = outstanding;
    case ({inc, pop})
      2'b10:   cnt_next = outstanding + CNT_W'(1);
      2'b01:   cnt_next = outstanding - CNT_W'(1);
      default: cnt_next = outstanding;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_r       <= 1'b0;
      outstanding <= '0;
      pipe_v      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      busy        <= 1'b0;
    end else begin
      rdy_r       <= 1'b1;
      outstanding <= cnt_next;
      busy        <= (cnt_next != '0);
      pipe_v      <= LAT'({pipe_v, inc});
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Tag leaving the pipe marks the cycle bram_do holds that request's data.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= bram_do;
    end
  end

endmodule

// File: tb/tb_bram_req_client.sv
// Bench for bram_req_client: behavioural BRAM models, expectation queue built from request semantics.
module tb_bram_req_client;
  localparam int unsigned AW = 10, DW = 32, WW = 4, DEPTH = 4;
  localparam int LAT0 = 1;
`ifdef BRAM_CLIENT_WRITE_ACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bram_req_client_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW)) b0 ();
  bram_req_client_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW)) b1 ();

  logic          busy0, busy1, en0, en1;
  logic [WW-1:0] we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] di0, di1, do0, do1, dq1;

  bram_req_client #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHUNKSIZE(8), .WE_WIDTH(WW),
                    .PIPELINED(0), .RESP_DEPTH(DEPTH)) dut0 (
    .CLK(clk), .RST_N(rst_n), .bus(b0.slave), .busy(busy0), .bram_en(en0),
    .bram_we(we0), .bram_addr(addr0), .bram_di(di0), .bram_do(do0));

  bram_req_client #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHUNKSIZE(8), .WE_WIDTH(WW),
                    .PIPELINED(1), .RESP_DEPTH(DEPTH)) dut1 (
    .CLK(clk), .RST_N(rst_n), .bus(b1.slave), .busy(busy1), .bram_en(en1),
    .bram_we(we1), .bram_addr(addr1), .bram_di(di1), .bram_do(do1));

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] di);
    logic [31:0] r = old;
    for (int l = 0; l < 4; l++) if (we[l]) r[l*8 +: 8] = di[l*8 +: 8];
    return r;
  endfunction

  // Write-first byte-enable BRAMs; the second has an extra output register.
  logic [31:0] bmem0 [1024];
  logic [31:0] bmem1 [1024];
  always @(posedge clk) if (en0) begin
    bmem0[addr0] <= merge(bmem0[addr0], we0, di0);
    do0          <= merge(bmem0[addr0], we0, di0);
  end
  always @(posedge clk) begin
    if (en1) begin
      bmem1[addr1] <= merge(bmem1[addr1], we1, di1);
      dq1          <= merge(bmem1[addr1], we1, di1);
    end
    do1 <= dq1;
  end

  typedef struct { logic [31:0] data; bit w; int rdy; } exp_t;
  exp_t        q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] v1 [16];
  int          n_tests = 0, n_fail = 0, cyc = 0;
  bit          rdy_m = 1'b0;
  bit          s_acc0, s_ready0, s_rv, s_rw, s_acc1, rec1 = 1'b0;
  logic [31:0] s_rd;
  int          s_cyc;
  int          acc1[$], gotc1[$];
  logic [31:0] got1[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected behaviour of dut0, evaluated once per cycle between edges.
  task automatic scoreboard();
    bit head_v, acc;
    exp_t e;
    logic [31:0] nw;
    if (!rst_n) begin
      q.delete();
      rdy_m = 1'b0;
      chk("rst_req_ready", 64'(b0.req_ready), 64'(0));
      chk("rst_resp_valid", 64'(b0.resp_valid), 64'(0));
      chk("rst_bram_en", 64'(en0), 64'(0));
      chk("rst_busy", 64'(busy0), 64'(0));
      chk("rst_is_write", 64'(b0.resp_is_write), 64'(0));
    end else begin
      chk("req_ready", 64'(b0.req_ready), 64'(rdy_m && (q.size() < DEPTH)));
      chk("busy", 64'(busy0), 64'(q.size() != 0));
      head_v = (q.size() > 0) && (q[0].rdy <= cyc);
      chk("resp_valid", 64'(b0.resp_valid), 64'(head_v));
      acc = b0.req_valid && b0.req_ready;
      chk("bram_en", 64'(en0), 64'(acc));
      chk("bram_we", 64'(we0), 64'(acc ? b0.req_we : 4'h0));
      if (acc) begin
        chk("bram_addr", 64'(addr0), 64'(b0.req_addr));
        chk("bram_di", 64'(di0), 64'(b0.req_data));
      end
      if (head_v && b0.resp_valid && b0.resp_ready) begin
        chk("resp_data", 64'(b0.resp_data), 64'(q[0].data));
        chk("resp_is_write", 64'(b0.resp_is_write), 64'(q[0].w));
        void'(q.pop_front());
      end
      if (acc) begin
        nw = merge(ref_mem[b0.req_addr[3:0]], b0.req_we, b0.req_data);
        if (b0.req_we == 4'h0 || WACK) begin
          e.data = (b0.req_we == 4'h0) ? ref_mem[b0.req_addr[3:0]] : nw;
          e.w    = (b0.req_we != 4'h0);
          e.rdy  = cyc + 1 + LAT0;
          q.push_back(e);
        end
        ref_mem[b0.req_addr[3:0]] = nw;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s_cyc    = cyc;
    s_acc0   = b0.req_valid && b0.req_ready;
    s_ready0 = b0.req_ready;
    s_rv     = b0.resp_valid;
    s_rw     = b0.resp_is_write;
    s_rd     = b0.resp_data;
    s_acc1   = b1.req_valid && b1.req_ready;
    if (rec1) begin
      if (s_acc1) acc1.push_back(cyc + 1);
      if (b1.resp_valid && b1.resp_ready && !b1.resp_is_write) begin
        got1.push_back(b1.resp_data);
        gotc1.push_back(cyc);
      end
    end
    scoreboard();
    @(posedge clk);
    if (rst_n) rdy_m = 1'b1;
    cyc++;
    #1;
  endtask

  task automatic send0(input logic [9:0] a, input logic [3:0] we, input logic [31:0] d,
                       output int t);
    bit done = 1'b0;
    t = -1;
    b0.req_valid = 1'b1; b0.req_addr = a; b0.req_we = we; b0.req_data = d;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (s_acc0) begin done = 1'b1; t = cyc; end
    end
    b0.req_valid = 1'b0; b0.req_we = 4'h0;
    chk("send_accepted", 64'(done), 64'(1));
  endtask

  task automatic wait_resp0(input bit want_w, input int t, input logic [31:0] expd,
                            input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (s_rv && (s_rw == want_w)) begin
        got = 1'b1;
        chk({tag, "_latency"}, 64'(s_cyc), 64'(t + LAT0));
        chk({tag, "_data"}, 64'(s_rd), 64'(expd));
      end
    end
    chk({tag, "_seen"}, 64'(got), 64'(1));
  endtask

  task automatic rand_drive0();
    b0.req_valid  = ($urandom_range(3) != 0);
    b0.req_addr   = 10'($urandom_range(15));
    b0.req_we     = ($urandom_range(1) != 0) ? 4'($urandom_range(15)) : 4'h0;
    b0.req_data   = $urandom;
    b0.resp_ready = ($urandom_range(3) != 0);
  endtask

  initial begin
    int t, k;
    bit ok;
    rst_n = 1'b0;
    b0.req_valid = 1'b0; b0.req_addr = '0; b0.req_we = '0; b0.req_data = '0; b0.resp_ready = 1'b1;
    b1.req_valid = 1'b0; b1.req_addr = '0; b1.req_we = '0; b1.req_data = '0; b1.resp_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;

    // Fill both BRAMs at addresses 0..15 so every later read has a known value.
    for (int a = 0; a < 16; a++) begin
      send0(10'(a), 4'hF, $urandom, t);
      v1[a] = $urandom;
      b1.req_valid = 1'b1; b1.req_addr = 10'(a); b1.req_we = 4'hF; b1.req_data = v1[a];
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = s_acc1; end
      b1.req_valid = 1'b0; b1.req_we = 4'h0;
      chk("prefill1_accept", 64'(ok), 64'(1));
    end
    b0.resp_ready = 1'b1;
    repeat (4) tick();

    // Reset in the middle of traffic.
    repeat (6) begin rand_drive0(); tick(); end
    rst_n = 1'b0;
    repeat (3) begin
      rand_drive0(); tick();
      chk("t1_ready_in_rst", 64'(s_ready0), 64'(0));
      chk("t1_valid_in_rst", 64'(s_rv), 64'(0));
    end
    rst_n = 1'b1;
    b0.req_valid = 1'b1; b0.req_we = 4'h0; b0.resp_ready = 1'b1;
    tick();
    chk("t1_ready_before_edge", 64'(s_ready0), 64'(0));
    tick();
    chk("t1_ready_after_edge", 64'(s_ready0), 64'(1));
    chk("t1_no_stale", 64'(s_rv), 64'(0));
    b0.req_valid = 1'b0;
    repeat (4) tick();

    // Full write then read back.
    send0(10'd5, 4'hF, 32'hDEADBEEF, t);
    send0(10'd5, 4'h0, 32'h0, t);
    wait_resp0(1'b0, t, 32'hDEADBEEF, "t2");
    repeat (3) tick();

    // Partial byte-lane write.
    send0(10'd7, 4'hF, 32'h11223344, t);
    send0(10'd7, 4'b0010, 32'h0000AA00, t);
    send0(10'd7, 4'h0, 32'h0, t);
    wait_resp0(1'b0, t, 32'h1122AA44, "t3");
    repeat (3) tick();

    // Credit limit with a stalled consumer.
    b0.resp_ready = 1'b0; k = 0;
    for (int i = 0; i < 10; i++) begin
      b0.req_valid = (k < 6); b0.req_addr = 10'(k); b0.req_we = 4'h0;
      tick();
      if (s_acc0) k++;
    end
    chk("t4_accepted_stalled", 64'(k), 64'(4));
    chk("t4_ready_low", 64'(s_ready0), 64'(0));
    b0.resp_ready = 1'b1;
    for (int i = 0; i < 20 && k < 6; i++) begin
      b0.req_valid = (k < 6); b0.req_addr = 10'(k);
      tick();
      if (s_acc0) k++;
    end
    b0.req_valid = 1'b0;
    chk("t4_accepted_total", 64'(k), 64'(6));
    repeat (6) tick();

`ifdef BRAM_CLIENT_WRITE_ACK_EN
    send0(10'd3, 4'hF, 32'hCAFEF00D, t);
    wait_resp0(1'b1, t, 32'hCAFEF00D, "t6");
    repeat (3) tick();
`endif

    // Pipelined instance: 16 back-to-back reads.
    rec1 = 1'b1; k = 0;
    for (int i = 0; i < 40 && k < 16; i++) begin
      b1.req_valid = 1'b1; b1.req_addr = 10'(k); b1.req_we = 4'h0;
      tick();
      if (s_acc1) k++;
    end
    b1.req_valid = 1'b0;
    repeat (8) tick();
    rec1 = 1'b0;
    chk("t5_accepts", 64'(acc1.size()), 64'(16));
    chk("t5_responses", 64'(got1.size()), 64'(16));
    if (acc1.size() > 0 && gotc1.size() > 0)
      chk("t5_first_latency", 64'(gotc1[0]), 64'(acc1[0] + 2));
    for (int i = 1; i < acc1.size(); i++)
      chk("t5_back_to_back", 64'(acc1[i]), 64'(acc1[0] + i));
    for (int i = 0; i < got1.size() && i < 16; i++)
      chk("t5_data_order", 64'(got1[i]), 64'(v1[i]));

    // Randomized traffic with a reset pulse part-way through.
    for (int i = 0; i < 300; i++) begin
      rst_n = !(i == 150 || i == 151);
      rand_drive0();
      tick();
    end
    rst_n = 1'b1;
    b0.req_valid = 1'b0; b0.resp_ready = 1'b1;
    repeat (12) tick();
    chk("drain_empty", 64'(q.size()), 64'(0));
    chk("drain_busy", 64'(busy0), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
